// File: rtl/truth_table_pkg.sv
// Shared types and constants for the truth-table sweeper and its MISR.
package truth_table_pkg;
  typedef enum logic [1:0] {IDLE, SWEEP, EMIT, DONE} state_t;

  localparam logic [15:0] MISR_POLY = 16'h100B;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;

  function automatic int idx_width(input int n_out);
    return (n_out <= 1) ? 1 : $clog2(n_out);
  endfunction
endpackage

// File: rtl/misr16.sv
// 16-bit multiple-input signature register; rst or clear reloads the seed.
module misr16
  import truth_table_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        en,
  input  logic [15:0] din,
  output logic [15:0] sig
);
  logic [15:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (en) begin
      sig_d = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? MISR_POLY : 16'h0000) ^ din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) sig_q <= MISR_SEED;
    else              sig_q <= sig_d;
  end

  assign sig = sig_q;
endmodule

// File: rtl/truth_table_sweeper.sv
// Walks all input vectors of a combinational circuit, builds one truth-table
// word per output, streams the words out and compacts responses into a MISR.
module truth_table_sweeper
  import truth_table_pkg::*;
#(
  parameter int N_IN   = 6,
  parameter int N_OUT  = 4,
  parameter int SETTLE = 1,
  localparam int TT_W  = 2 ** N_IN,
  localparam int IDX_W = idx_width(N_OUT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic [N_IN-1:0]  x,
  input  logic [N_OUT-1:0] f,
  output logic             tt_valid,
  input  logic             tt_ready,
  output logic [TT_W-1:0]  tt_data,
  output logic [IDX_W-1:0] tt_idx,
  output logic             tt_last,
  output logic [15:0]      sig,
  output logic             done
);
  localparam int SCNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SCNT_W-1:0] SETTLE_LAST = SCNT_W'(SETTLE - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST    = IDX_W'(N_OUT - 1);

  state_t                        state_q, state_d;
  logic [N_IN-1:0]               x_q, x_d;
  logic [SCNT_W-1:0]             scnt_q, scnt_d;
  logic                          busy_q, busy_d;
  logic                          valid_q, valid_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic                          done_q, done_d;
  logic [N_OUT-1:0][TT_W-1:0]    tt_q, tt_d;
  logic                          misr_clear, misr_en;
  logic [15:0]                   misr_din;

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    scnt_d     = scnt_q;
    busy_d     = busy_q;
    valid_d    = valid_q;
    idx_d      = idx_q;
    done_d     = 1'b0;
    tt_d       = tt_q;
    misr_clear = 1'b0;
    misr_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = SWEEP;
          x_d        = '0;
          scnt_d     = '0;
          idx_d      = '0;
          tt_d       = '0;
          busy_d     = 1'b1;
          misr_clear = 1'b1;
        end
      end
      SWEEP: begin
        if (scnt_q == SETTLE_LAST) begin
          misr_en = 1'b1;
          for (int j = 0; j < N_OUT; j++) tt_d[j][x_q] = f[j];
          // x stops at the last pattern rather than wrapping back to 0
          if (x_q != '1) begin
            x_d    = x_q + 1'b1;
            scnt_d = '0;
          end else begin
            state_d = EMIT;
            idx_d   = '0;
            valid_d = 1'b1;
          end
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end
      EMIT: begin
        if (valid_q && tt_ready) begin
          if (idx_q == IDX_LAST) begin
            state_d = DONE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    misr_din            = '0;
    misr_din[N_OUT-1:0] = f;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      scnt_q  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      tt_q    <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      scnt_q  <= scnt_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      tt_q    <= tt_d;
    end
  end

  misr16 u_misr (
    .clk   (clk),
    .rst   (rst),
    .clear (misr_clear),
    .en    (misr_en),
    .din   (misr_din),
    .sig   (sig)
  );

  assign busy     = busy_q;
  assign x        = x_q;
  assign tt_valid = valid_q;
  assign tt_idx   = idx_q;
  assign tt_data  = valid_q ? tt_q[idx_q] : '0;
  assign tt_last  = valid_q && (idx_q == IDX_LAST);
  assign done     = done_q;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: one sweeper with combinational f (SETTLE=1) and one with
// a two-clock delayed f (SETTLE=3), checked against hand-computed words.
module tb_truth_table_sweeper;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, start1 = 1'b0, start3 = 1'b0, tt_ready = 1'b1;
  logic        fzero = 1'b0, sel = 1'b0;
  logic        busy1, valid1, last1, done1, busy3, valid3, last3, done3;
  logic [5:0]  x1, x3;
  logic [3:0]  f1, f3, f3_d1, f3_d2;
  logic [63:0] data1, data3;
  logic [1:0]  idx1, idx3;
  logic [15:0] sig1, sig3;

  int n_tests = 0, n_fail = 0;
  int nw, ndone, cyc = 0, last_hs, done_cyc;
  logic [63:0] w_data [8];
  logic [1:0]  w_idx  [8];
  logic        w_last [8];
  logic        stall_prev = 1'b0;
  logic [63:0] hold_data;
  logic [1:0]  hold_idx;
  bit          pat [8] = '{1, 0, 0, 1, 0, 1, 1, 0};
  logic [63:0] exp_w [4] = '{64'h6666666666666666, 64'hF000F000F000F000,
                             64'h0000FFFF0000FFFF, 64'hFFFFFFFF00000000};

  function automatic logic [3:0] model(input logic [5:0] xv);
    return {xv[5], ~xv[4], xv[2] & xv[3], xv[0] ^ xv[1]};
  endfunction

  function automatic logic [15:0] gold_sig(input bit zero);
    logic [15:0] s = 16'hFFFF;
    logic [3:0]  fv;
    for (int i = 0; i < 64; i++) begin
      fv = zero ? 4'h0 : model(6'(i));
      s  = {s[14:0], 1'b0} ^ (s[15] ? 16'h100B : 16'h0000) ^ {12'h000, fv};
    end
    return s;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  assign f1 = fzero ? 4'h0 : model(x1);
  always @(posedge clk) begin
    f3_d1 <= model(x3);
    f3_d2 <= f3_d1;
  end
  assign f3 = f3_d2;

  truth_table_sweeper #(.N_IN(6), .N_OUT(4), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .x(x1), .f(f1),
    .tt_valid(valid1), .tt_ready(tt_ready), .tt_data(data1), .tt_idx(idx1),
    .tt_last(last1), .sig(sig1), .done(done1));

  truth_table_sweeper #(.N_IN(6), .N_OUT(4), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .busy(busy3), .x(x3), .f(f3),
    .tt_valid(valid3), .tt_ready(tt_ready), .tt_data(data3), .tt_idx(idx3),
    .tt_last(last3), .sig(sig3), .done(done3));

  wire        m_valid = sel ? valid3 : valid1;
  wire        m_busy  = sel ? busy3  : busy1;
  wire        m_last  = sel ? last3  : last1;
  wire        m_done  = sel ? done3  : done1;
  wire [63:0] m_data  = sel ? data3  : data1;
  wire [1:0]  m_idx   = sel ? idx3   : idx1;

  // Handshake monitor: records accepted words and checks stall stability.
  always @(posedge clk) begin
    cyc++;
    if (stall_prev) begin
      check("stall_data", m_data, hold_data);
      check("stall_idx", 64'(m_idx), 64'(hold_idx));
      check("stall_valid", 64'(m_valid), 64'd1);
    end
    stall_prev = m_valid && !tt_ready;
    hold_data  = m_data;
    hold_idx   = m_idx;
    if (m_valid && tt_ready) begin
      if (nw < 8) begin
        w_data[nw] = m_data;
        w_idx[nw]  = m_idx;
        w_last[nw] = m_last;
      end
      nw++;
      last_hs = cyc;
    end
    if (m_done) begin
      ndone++;
      done_cyc = cyc;
    end
  end

  task automatic run(input bit use3, input bit rdy_pat, input bit inject,
                     output int busy_cyc, output int sweep_cyc);
    bit seen_v = 0, emit_inj = 0, finished = 0;
    busy_cyc = 0; sweep_cyc = 0;
    nw = 0; ndone = 0; stall_prev = 1'b0; sel = use3;
    @(negedge clk);
    if (use3) start3 = 1'b1; else start1 = 1'b1;
    for (int k = 0; k < 2000 && !finished; k++) begin
      @(negedge clk);
      start1 = 1'b0; start3 = 1'b0;
      if (inject && (k == 10 || (m_valid && !emit_inj))) begin
        if (use3) start3 = 1'b1; else start1 = 1'b1;
        if (m_valid) emit_inj = 1;
      end
      tt_ready = rdy_pat ? pat[k % 8] : 1'b1;
      if (m_busy) busy_cyc++;
      if (m_valid) seen_v = 1;
      if (m_busy && !seen_v) sweep_cyc++;
      if (ndone > 0 && !m_busy) finished = 1;
    end
    start1 = 1'b0; start3 = 1'b0; tt_ready = 1'b1;
    check("timeout", 64'(finished), 64'd1);
  endtask

  task automatic check_words(input string tag, input bit zero);
    check({tag, "_nwords"}, 64'(nw), 64'd4);
    check({tag, "_ndone"}, 64'(ndone), 64'd1);
    check({tag, "_done_lat"}, 64'(done_cyc - last_hs), 64'd1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_data%0d", tag, i), w_data[i], zero ? 64'h0 : exp_w[i]);
      check($sformatf("%s_idx%0d", tag, i), 64'(w_idx[i]), 64'(i));
      check($sformatf("%s_last%0d", tag, i), 64'(w_last[i]), 64'(i == 3));
    end
  endtask

  initial begin
    int bc, sc;
    bit hit;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_x", 64'(x1), 64'd0);
    check("rst_busy", 64'(busy1), 64'd0);
    check("rst_valid", 64'(valid1), 64'd0);
    check("rst_data", data1, 64'd0);
    check("rst_idx", 64'(idx1), 64'd0);
    check("rst_last", 64'(last1), 64'd0);
    check("rst_done", 64'(done1), 64'd0);
    check("rst_sig", 64'(sig1), 64'hFFFF);
    check("rst_sig3", 64'(sig3), 64'hFFFF);

    // Basic sweep, SETTLE=1, ready always high
    run(0, 0, 0, bc, sc);
    check_words("s1", 0);
    check("s1_busy", 64'(bc), 64'd69);
    check("s1_sweep", 64'(sc), 64'd64);
    check("s1_sig", 64'(sig1), 64'(gold_sig(0)));
    check("s1_x_hold", 64'(x1), 64'd63);

    // SETTLE=3 with f lagging x by two clocks
    run(1, 0, 0, bc, sc);
    check_words("s3", 0);
    check("s3_sweep", 64'(sc), 64'd192);
    check("s3_busy", 64'(bc), 64'd197);
    check("s3_sig", 64'(sig3), 64'(gold_sig(0)));

    // Backpressure during EMIT
    run(0, 1, 0, bc, sc);
    check_words("bp", 0);

    // start pulses during SWEEP and EMIT are dropped
    run(0, 0, 1, bc, sc);
    check_words("inj", 0);
    repeat (5) @(negedge clk);
    check("inj_idle_busy", 64'(busy1), 64'd0);
    check("inj_ndone", 64'(ndone), 64'd1);

    // Reset in the middle of a sweep
    sel = 1'b0; nw = 0; ndone = 0;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    hit = 0;
    for (int k = 0; k < 200 && !hit; k++) begin
      if (x1 == 6'd30) hit = 1;
      else @(negedge clk);
    end
    check("mid_reach30", 64'(hit), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_x", 64'(x1), 64'd0);
    check("mid_busy", 64'(busy1), 64'd0);
    check("mid_valid", 64'(valid1), 64'd0);
    check("mid_sig", 64'(sig1), 64'hFFFF);
    repeat (3) @(negedge clk);
    check("mid_nodone", 64'(ndone), 64'd0);
    check("mid_nowords", 64'(nw), 64'd0);
    run(0, 0, 0, bc, sc);
    check_words("post", 0);
    check("post_sig", 64'(sig1), 64'(gold_sig(0)));

    // All-zero response
    fzero = 1'b1;
    run(0, 0, 0, bc, sc);
    check_words("zero", 1);
    check("zero_sig", 64'(sig1), 64'(gold_sig(1)));
    fzero = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
